// File: rtl/fpu_mant_seq_divider.sv
// rtl/fpu_mant_seq_divider.sv - radix-2 restoring significand divider, one quotient bit per clock
// Optional build macro: FPU_DIV_EARLY_TERM_EN (stop as soon as the partial remainder reaches zero)
module fpu_mant_seq_divider #(
   parameter int MANT_W = 24,
   parameter int QUOT_W = 26
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MANT_W-1:0] mantissa_num1,
   input  logic [MANT_W-1:0] mantissa_num2,
   output logic              busy,
   output logic              done,
   output logic [QUOT_W-1:0] quotient,
   output logic              sticky,
   output logic              div_by_zero
);

   localparam int CNT_W = (QUOT_W > 2) ? $clog2(QUOT_W) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(QUOT_W - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [MANT_W-1:0] divisor;
   logic [MANT_W-1:0] rem;
   logic [CNT_W-1:0]  k;

   logic [MANT_W:0]   t;
   logic              q_bit;
   logic [MANT_W-1:0] diff;
   logic [MANT_W-1:0] rem_next;
   logic [QUOT_W-1:0] quot_next;

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   // The first step compares the unshifted dividend so that bit QUOT_W-1 carries weight 2^0.
   always_comb begin
      t         = (k == '0) ? {1'b0, rem} : {rem, 1'b0};
      q_bit     = (t >= {1'b0, divisor});
      diff      = t[MANT_W-1:0] - divisor;
      rem_next  = q_bit ? diff : t[MANT_W-1:0];
      quot_next = {quotient[QUOT_W-2:0], q_bit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         divisor     <= '0;
         rem         <= '0;
         k           <= '0;
         quotient    <= '0;
         sticky      <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  divisor <= mantissa_num2;
                  rem     <= mantissa_num1;
                  k       <= '0;
                  sticky  <= 1'b0;
                  if (mantissa_num2 == '0) begin
                     quotient    <= '1;
                     div_by_zero <= 1'b1;
                     state       <= S_DONE;
                  end else begin
                     quotient    <= '0;
                     div_by_zero <= 1'b0;
                     state       <= S_RUN;
                  end
               end else if (state == S_DONE) begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               rem      <= rem_next;
               quotient <= quot_next;
               k        <= k + 1'b1;
               if (k == LAST_K) begin
                  sticky <= |rem_next;
                  state  <= S_DONE;
               end
`ifdef FPU_DIV_EARLY_TERM_EN
               // Zero remainder means every remaining quotient bit is zero.
               else if (rem_next == '0) begin
                  quotient <= quot_next << (LAST_K - k);
                  sticky   <= 1'b0;
                  state    <= S_DONE;
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mant_seq_divider.sv
// tb/tb_fpu_mant_seq_divider.sv - randomized self-checking bench for fpu_mant_seq_divider
// Honours FPU_DIV_EARLY_TERM_EN when computing expected latency.
module tb_fpu_mant_seq_divider;

   localparam int MANT_W = 24;
   localparam int QUOT_W = 26;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [MANT_W-1:0] mantissa_num1 = '0;
   logic [MANT_W-1:0] mantissa_num2 = '0;
   logic              busy;
   logic              done;
   logic [QUOT_W-1:0] quotient;
   logic              sticky;
   logic              div_by_zero;

   fpu_mant_seq_divider #(.MANT_W(MANT_W), .QUOT_W(QUOT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .mantissa_num1 (mantissa_num1),
      .mantissa_num2 (mantissa_num2),
      .busy          (busy),
      .done          (done),
      .quotient      (quotient),
      .sticky        (sticky),
      .div_by_zero   (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [QUOT_W-1:0] q;
      logic              s;
      logic              z;
      int                done_cyc;
   } exp_t;

   exp_t exp_q[$];
   logic [QUOT_W-1:0] hold_q = '0;
   logic              hold_s = 1'b0;
   logic              hold_z = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: exact integer quotient; latency from the first step whose partial remainder is zero.
   task automatic model(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                        output logic [QUOT_W-1:0] q, output logic s, output int lat);
      longint unsigned num;
      if (b == '0) begin
         q   = '1;
         s   = 1'b0;
         lat = 0;
      end else begin
         num = longint'(a) << (QUOT_W - 1);
         q   = QUOT_W'(num / longint'(b));
         s   = (num % longint'(b)) != 0;
         lat = QUOT_W;
`ifdef FPU_DIV_EARLY_TERM_EN
         for (int i = 0; i < QUOT_W; i++) begin
            if (((longint'(a) << i) % longint'(b)) == 0) begin
               lat = i + 1;
               break;
            end
         end
`endif
      end
   endtask

   // Per-cycle compare against the model's expected timeline.
   logic exp_busy, exp_done;
   always @(negedge clk) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (exp_q.size() > 0) begin
         exp_busy = !exp_q[0].z && (cyc < exp_q[0].done_cyc);
         exp_done = (cyc == exp_q[0].done_cyc);
      end
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (busy && done) check("busy_and_done", 32'(busy & done), 32'd0);
      if (exp_done) begin
         check("quotient", 32'(quotient), 32'(exp_q[0].q));
         check("sticky", 32'(sticky), 32'(exp_q[0].s));
         check("div_by_zero", 32'(div_by_zero), 32'(exp_q[0].z));
         hold_q = exp_q[0].q;
         hold_s = exp_q[0].s;
         hold_z = exp_q[0].z;
         void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
         check("hold_quotient", 32'(quotient), 32'(hold_q));
         check("hold_sticky", 32'(sticky), 32'(hold_s));
         check("hold_div_by_zero", 32'(div_by_zero), 32'(hold_z));
      end
   end

   // Called at posedge+1 with the DUT in IDLE or DONE; returns at posedge+1 after the accepting edge.
   task automatic issue(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                        output int lat);
      exp_t e;
      mantissa_num1 = a;
      mantissa_num2 = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      mantissa_num1 = 24'($urandom);
      mantissa_num2 = 24'($urandom);
      model(a, b, e.q, e.s, lat);
      e.z = (b == '0);
      e.done_cyc = cyc + lat;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_one(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                          input bit poke, input bit b2b);
      int lat;
      int waited;
      issue(a, b, lat);
      waited = 0;
      if (poke && lat >= 4) begin
         tick(1);
         start = 1'b1;
         mantissa_num1 = 24'($urandom);
         mantissa_num2 = 24'($urandom);
         tick(1);
         start = 1'b0;
         mantissa_num1 = 24'($urandom);
         waited = 2;
      end
      tick(lat - waited);
      if (!b2b) tick(1);
   endtask

   logic [QUOT_W-1:0] mq;
   logic              ms;
   int                ml;
   int                lat0;
   logic [MANT_W-1:0] ra, rb;

   initial begin
      // Pin the reference model to hand-computed values.
      model(24'h800000, 24'h800000, mq, ms, ml);
      check("model_1_1_q", 32'(mq), 32'h2000000);
      check("model_1_1_s", 32'(ms), 32'd0);
`ifdef FPU_DIV_EARLY_TERM_EN
      check("model_1_1_lat", 32'(ml), 32'd1);
`else
      check("model_1_1_lat", 32'(ml), 32'd26);
`endif
      model(24'hC00000, 24'h800000, mq, ms, ml);
      check("model_c_8_q", 32'(mq), 32'h3000000);
      model(24'h800000, 24'hC00000, mq, ms, ml);
      check("model_8_c_q", 32'(mq), 32'h1555555);
      check("model_8_c_s", 32'(ms), 32'd1);
      check("model_8_c_lat", 32'(ml), 32'd26);
      model(24'hFFFFFF, 24'h800000, mq, ms, ml);
      check("model_f_8_q", 32'(mq), 32'h3FFFFFC);
      check("model_f_8_s", 32'(ms), 32'd0);
      model(24'h800000, 24'hFFFFFF, mq, ms, ml);
      check("model_8_f_q", 32'(mq), 32'd16777217);
      check("model_8_f_s", 32'(ms), 32'd1);
      model(24'h123456, 24'h000000, mq, ms, ml);
      check("model_dbz_q", 32'(mq), 32'h3FFFFFF);

      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Abort a divide with reset; no done may follow.
      issue(24'h800000, 24'hC00000, lat0);
      tick(10);
      rst_n = 1'b0;
      exp_q.delete();
      hold_q = '0;
      hold_s = 1'b0;
      hold_z = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(30);

      run_one(24'h800000, 24'h800000, 1'b0, 1'b0);
      run_one(24'hC00000, 24'h800000, 1'b0, 1'b0);
      run_one(24'h800000, 24'hC00000, 1'b1, 1'b0);
      run_one(24'hFFFFFF, 24'h800000, 1'b0, 1'b1);
      run_one(24'h800000, 24'hFFFFFF, 1'b0, 1'b0);
      run_one(24'h5A5A5A, 24'h000000, 1'b0, 1'b0);
      tick(3);

      for (int i = 0; i < 40; i++) begin
         ra = 24'h800000 | 24'($urandom);
         rb = 24'h800000 | 24'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            ra = ra & 24'hFFF000;
            rb = rb & 24'hFC0000;
         end
         if ($urandom_range(0, 7) == 0) rb = '0;
         run_one(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      end

      for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick(1);
      if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
